// File: rtl/pool2_window_collector.sv
// Groups the 8-channel conv-2 sample stream into non-overlapping WIN-sample
// windows per channel and hands each complete window to the second max-pool layer.
module pool2_window_collector #(
    parameter int WIDTH = 8,
    parameter int WIN   = 5,
    parameter int NWIN  = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0][WIDTH-1:0]      in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIN-1:0][WIDTH-1:0]  out1,
    output logic [WIN-1:0][WIDTH-1:0]  out2,
    output logic [WIN-1:0][WIDTH-1:0]  out3,
    output logic [WIN-1:0][WIDTH-1:0]  out4,
    output logic [WIN-1:0][WIDTH-1:0]  out5,
    output logic [WIN-1:0][WIDTH-1:0]  out6,
    output logic [WIN-1:0][WIDTH-1:0]  out7,
    output logic [WIN-1:0][WIDTH-1:0]  out8,
    output logic                       out_last,
    output logic                       en
);

    localparam int CW  = $clog2(WIN);
    localparam int WCW = $clog2(NWIN);

    logic [7:0][WIN-2:0][WIDTH-1:0] fill_buf;
    logic [CW-1:0]                  fill_cnt;
    logic [WCW-1:0]                 win_cnt;
    logic [7:0][WIN-1:0][WIDTH-1:0] win_reg;
    logic [7:0][WIN-1:0][WIDTH-1:0] win_next;
    logic                           accept;
    logic                           complete;
    logic                           last_next;

    assign in_ready  = !out_valid || out_ready;
    assign en        = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    assign complete  = accept && ((fill_cnt == CW'(WIN - 1)) || in_last);
    assign last_next = in_last || (win_cnt == WCW'(NWIN - 1));

    // Slots beyond the incoming sample stay zero, which pads a partial window
    // without disturbing the max over non-negative data.
    always_comb begin
        win_next = '0;
        for (int c = 0; c < 8; c++) begin
            for (int e = 0; e < WIN - 1; e++) begin
                if (CW'(e) < fill_cnt) begin
                    win_next[c][e] = fill_buf[c][e];
                end else if (CW'(e) == fill_cnt) begin
                    win_next[c][e] = in_data[c];
                end
            end
            if (fill_cnt == CW'(WIN - 1)) begin
                win_next[c][WIN-1] = in_data[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_buf <= '0;
            fill_cnt <= '0;
        end else if (accept) begin
            if (complete) begin
                fill_cnt <= '0;
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
                for (int c = 0; c < 8; c++) begin
                    for (int e = 0; e < WIN - 1; e++) begin
                        if (CW'(e) == fill_cnt) begin
                            fill_buf[c][e] <= in_data[c];
                        end
                    end
                end
            end
        end
    end

    // A completion in the same cycle as consumption reloads the output
    // registers and keeps out_valid high, so back-to-back windows have no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_reg   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            win_cnt   <= '0;
        end else if (complete) begin
            win_reg   <= win_next;
            out_valid <= 1'b1;
            out_last  <= last_next;
            win_cnt   <= last_next ? '0 : win_cnt + 1'b1;
        end else if (en) begin
            out_valid <= 1'b0;
        end
    end

    assign out1 = win_reg[0];
    assign out2 = win_reg[1];
    assign out3 = win_reg[2];
    assign out4 = win_reg[3];
    assign out5 = win_reg[4];
    assign out6 = win_reg[5];
    assign out7 = win_reg[6];
    assign out8 = win_reg[7];

endmodule

// File: tb/tb_pool2_window_collector.sv
// Directed self-checking bench for pool2_window_collector: reset, basic window,
// backpressure, partial frame, full 36-window frame and asynchronous mid-window reset.
module tb_pool2_window_collector;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0][7:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [4:0][7:0]  out1, out2, out3, out4, out5, out6, out7, out8;
    logic             out_last;
    logic             en;

    int compared;
    int mismatched;

    pool2_window_collector #(.WIDTH(8), .WIN(5), .NWIN(36)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out5(out5), .out6(out6), .out7(out7), .out8(out8),
        .out_last(out_last), .en(en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel c (0-based) carries base + step*c.
    function automatic logic [7:0][7:0] gen(input int base, input int step);
        logic [7:0][7:0] d;
        for (int c = 0; c < 8; c++) d[c] = 8'(base + step * c);
        return d;
    endfunction

    // Element 0 (oldest) sits in the low byte.
    function automatic logic [39:0] win5(input int e0, input int e1, input int e2,
                                         input int e3, input int e4);
        return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic feed(input int base, input int step, input logic last);
        in_valid = 1'b1;
        in_data  = gen(base, step);
        in_last  = last;
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_en",        64'(en),        64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out1",      64'(out1),      64'd0);
        check("rst_out8",      64'(out8),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        #20 rst = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic window: channel c+1 gets 10(c+1)+k
        for (int k = 0; k < 4; k++) feed(10 + k, 10, 1'b0);
        check("basic_no_early_valid", 64'(out_valid), 64'd0);
        feed(14, 10, 1'b0);
        check("basic_out_valid", 64'(out_valid), 64'd1);
        check("basic_out1",      64'(out1), 64'(win5(10, 11, 12, 13, 14)));
        check("basic_out8",      64'(out8), 64'(win5(80, 81, 82, 83, 84)));
        check("basic_en",        64'(en),       64'd1);
        check("basic_out_last",  64'(out_last), 64'd0);
        in_valid = 1'b0;
        tick();
        check("basic_en_one_cycle", 64'(en),        64'd0);
        check("basic_valid_clear",  64'(out_valid), 64'd0);

        // Backpressure: window 100..104 held while sample 105 waits
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) feed(100 + k, 1, 1'b0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        in_data  = gen(105, 1);
        in_valid = 1'b1;
        for (int j = 0; j < 7; j++) begin
            #1;
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_en_low",       64'(en),       64'd0);
            check("bp_out1_stable",  64'(out1), 64'(win5(100, 101, 102, 103, 104)));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_en",       64'(en),       64'd1);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_consumed", 64'(out_valid), 64'd0);
        for (int k = 6; k < 10; k++) feed(100 + k, 1, 1'b0);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_out1",  64'(out1), 64'(win5(105, 106, 107, 108, 109)));
        check("bp_next_out8",  64'(out8), 64'(win5(112, 113, 114, 115, 116)));
        check("bp_next_last",  64'(out_last), 64'd0);

        // Partial frame: in_last on third sample
        feed(7, 1, 1'b0);
        feed(9, 1, 1'b0);
        feed(4, 1, 1'b1);
        in_last = 1'b0;
        check("part_out_valid", 64'(out_valid), 64'd1);
        check("part_out1",      64'(out1), 64'(win5(7, 9, 4, 0, 0)));
        check("part_out8",      64'(out8), 64'(win5(14, 16, 11, 0, 0)));
        check("part_out_last",  64'(out_last), 64'd1);

        // Full frame of 180 samples; out_last only from the window counter on window 36
        for (int i = 0; i < 180; i++) begin
            feed(i, 1, 1'b0);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            if (i % 5 == 4) begin
                check("stream_out_valid", 64'(out_valid), 64'd1);
                check("stream_out1", 64'(out1), 64'(win5(i - 4, i - 3, i - 2, i - 1, i)));
                check("stream_out_last", 64'(out_last), 64'(i == 179));
            end else begin
                check("stream_gap_valid", 64'(out_valid), 64'd0);
            end
        end

        // Asynchronous reset with 3 samples of a new window pending
        for (int k = 0; k < 8; k++) feed(60 + k, 1, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_out1_held", 64'(out1), 64'(win5(60, 61, 62, 63, 64)));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_last",  64'(out_last),  64'd0);
        check("mid_rst_en",        64'(en),        64'd0);
        check("mid_rst_out1",      64'(out1),      64'd0);
        check("mid_rst_out8",      64'(out8),      64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        #2 rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) feed(70 + k, 1, 1'b0);
        check("after_rst_no_early", 64'(out_valid), 64'd0);
        feed(74, 1, 1'b0);
        in_valid = 1'b0;
        check("after_rst_valid",    64'(out_valid), 64'd1);
        check("after_rst_out1",     64'(out1), 64'(win5(70, 71, 72, 73, 74)));
        check("after_rst_out8",     64'(out8), 64'(win5(77, 78, 79, 80, 81)));
        check("after_rst_out_last", 64'(out_last), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
